// File: rtl/spike_event_reader_if.sv
// ----------------------------------------------------------------------------
// spike_fifo_if
// Read-side handshake between the SNN output spike FIFO and its consumer.
//   snn_event_n      FIFO empty flag (low = at least one event pending)
//   neuron_addr_out  FIFO read data, valid the cycle after snn_ren is sampled
//   snn_ren          one-cycle read-enable pulse, pops one entry
// Modports:
//   master  the consumer (spike_event_reader): drives snn_ren
//   slave   the FIFO: drives the empty flag and read data
// ----------------------------------------------------------------------------
interface spike_fifo_if;
    logic       snn_event_n;
    logic [3:0] neuron_addr_out;
    logic       snn_ren;

    modport master (
        input  snn_event_n,
        input  neuron_addr_out,
        output snn_ren
    );

    modport slave (
        output snn_event_n,
        output neuron_addr_out,
        input  snn_ren
    );
endinterface

// File: rtl/spike_event_reader.sv
// ----------------------------------------------------------------------------
// spike_event_reader
// Pops neuron-address spike events from the SNN output FIFO (two-cycle read
// handshake), keeps a saturating spike count per output neuron, and at the
// end of each classification window scans the 16 counts, reports the winner
// and clears the counts. A host port reads any neuron's count at any time.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   fifo          spike_fifo_if.master (snn_event_n, neuron_addr_out, snn_ren)
//   enable        low: no new reads issued, window counter holds
//   rd_addr       host readout neuron select
//   rd_count      count of neuron rd_addr, one cycle latency
//   winner        highest-count neuron of the last window (lowest index on tie)
//   winner_count  count of winner
//   no_spikes     every count was zero in the last window
//   result_valid  one-cycle pulse when winner/winner_count/no_spikes update
// ----------------------------------------------------------------------------
module spike_event_reader #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int COUNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    spike_fifo_if.master       fifo,
    input  logic               enable,
    input  logic [3:0]         rd_addr,
    output logic [COUNT_W-1:0] rd_count,
    output logic [3:0]         winner,
    output logic [COUNT_W-1:0] winner_count,
    output logic               no_spikes,
    output logic               result_valid
);
    localparam int                 N_NEURONS = 16;
    localparam int                 WIN_W     = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        EVAL,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               pending_q, pending_d;
    logic [COUNT_W-1:0] cnt_q [N_NEURONS];
    logic [3:0]         eval_idx_q;
    logic [COUNT_W-1:0] max_q;
    logic [3:0]         max_idx_q;
    logic [COUNT_W-1:0] rd_count_q;
    logic [3:0]         winner_q;
    logic [COUNT_W-1:0] winner_count_q;
    logic               no_spikes_q;
    logic               result_valid_q;

    // Combinational from state so an asynchronous reset drops it immediately.
    assign fifo.snn_ren = (state_q == READ);

    assign rd_count     = rd_count_q;
    assign winner       = winner_q;
    assign winner_count = winner_count_q;
    assign no_spikes    = no_spikes_q;
    assign result_valid = result_valid_q;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        pending_d = pending_q;

        // Window time only advances while the reader is in its event loop;
        // the evaluation pass does not eat into the next window.
        if (enable && (state_q == IDLE || state_q == READ || state_q == CAPTURE)) begin
            if (win_q == WIN_LAST) begin
                win_d     = '0;
                pending_d = 1'b1;
            end else begin
                win_d = win_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // A pending window end wins over a waiting event, so events
                // stay queued in the FIFO until the next window.
                if (pending_q) begin
                    state_d = EVAL;
                end else if (enable && !fifo.snn_event_n) begin
                    state_d = READ;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            EVAL: begin
                if (eval_idx_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            win_q          <= '0;
            pending_q      <= 1'b0;
            eval_idx_q     <= '0;
            max_q          <= '0;
            max_idx_q      <= '0;
            rd_count_q     <= '0;
            winner_q       <= '0;
            winner_count_q <= '0;
            no_spikes_q    <= 1'b0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            pending_q      <= pending_d;
            // Registered one cycle after DONE so it lines up with the new result.
            result_valid_q <= (state_q == DONE);
            // Sampled before the DONE clear lands: a read issued in DONE
            // returns the pre-clear count.
            rd_count_q     <= cnt_q[rd_addr];

            case (state_q)
                IDLE: begin
                    // Seed the scan with neuron 0; EVAL cycle 0 then compares
                    // it against itself and never replaces it.
                    eval_idx_q <= '0;
                    max_q      <= cnt_q[0];
                    max_idx_q  <= '0;
                end
                CAPTURE: begin
                    if (cnt_q[fifo.neuron_addr_out] != CNT_MAX) begin
                        cnt_q[fifo.neuron_addr_out] <= cnt_q[fifo.neuron_addr_out] + 1'b1;
                    end
                end
                EVAL: begin
                    // Strictly greater only: lowest index wins a tie.
                    if (cnt_q[eval_idx_q] > max_q) begin
                        max_q     <= cnt_q[eval_idx_q];
                        max_idx_q <= eval_idx_q;
                    end
                    eval_idx_q <= eval_idx_q + 1'b1;
                end
                DONE: begin
                    winner_q       <= max_idx_q;
                    winner_count_q <= max_q;
                    no_spikes_q    <= (max_q == '0);
                    for (int i = 0; i < N_NEURONS; i++) begin
                        cnt_q[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_event_reader.sv
module tb_spike_event_reader;
    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_count;
    logic [3:0] winner;
    logic [7:0] winner_count;
    logic       no_spikes;
    logic       result_valid;

    logic [3:0] rd_addr_s = 4'd2;
    logic [1:0] rd_count_s;
    logic [3:0] winner_s;
    logic [1:0] winner_count_s;
    logic       no_spikes_s;
    logic       result_valid_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spike_fifo_if fifo_m ();
    spike_fifo_if fifo_s ();

    // Main DUT: WINDOW_CYCLES=64, COUNT_W=8
    spike_event_reader #(.WINDOW_CYCLES(64), .COUNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo         (fifo_m),
        .enable       (enable),
        .rd_addr      (rd_addr),
        .rd_count     (rd_count),
        .winner       (winner),
        .winner_count (winner_count),
        .no_spikes    (no_spikes),
        .result_valid (result_valid)
    );

    // Saturation DUT: WINDOW_CYCLES=256, COUNT_W=2
    spike_event_reader #(.WINDOW_CYCLES(256), .COUNT_W(2)) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .fifo         (fifo_s),
        .enable       (1'b1),
        .rd_addr      (rd_addr_s),
        .rd_count     (rd_count_s),
        .winner       (winner_s),
        .winner_count (winner_count_s),
        .no_spikes    (no_spikes_s),
        .result_valid (result_valid_s)
    );

    // FIFO model for the main DUT
    logic [3:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [3:0] fifo_dout = 4'd0;
    logic       flush = 1'b0;

    assign fifo_m.snn_event_n     = (rd_ptr == wr_ptr);
    assign fifo_m.neuron_addr_out = fifo_dout;

    always @(posedge clock) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_m.snn_ren) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // History of snn_ren over the last 17 rising edges, plus back-to-back detect
    logic [16:0] ren_hist = '0;
    logic        ren_prev = 1'b0;
    logic        b2b      = 1'b0;
    always @(posedge clock) begin
        ren_hist <= {ren_hist[15:0], fifo_m.snn_ren};
        ren_prev <= fifo_m.snn_ren;
        if (fifo_m.snn_ren && ren_prev) b2b <= 1'b1;
    end

    // Saturation DUT source: always neuron 2, offers sat_target events
    int sat_pops   = 0;
    int sat_target = 0;
    assign fifo_s.snn_event_n     = (sat_pops >= sat_target);
    assign fifo_s.neuron_addr_out = 4'd2;
    always @(posedge clock) begin
        if (fifo_s.snn_ren) sat_pops <= sat_pops + 1;
    end

    typedef struct {
        int              n;
        logic [7:0][3:0] ev;
        logic [3:0]      w;
        logic [7:0]      wc;
        logic            none;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a);
        mem[wr_ptr[7:0]] = a;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("result_valid timeout", 0, 1);
    endtask

    task automatic wait_result_sat(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clock);
            if (result_valid_s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("sat result_valid timeout", 0, 1);
    endtask

    function automatic int exp_cnt(input int v, input logic [3:0] a);
        int c = 0;
        for (int i = 0; i < vecs[v].n; i++) begin
            if (vecs[v].ev[i] == a) c++;
        end
        return c;
    endfunction

    initial begin
        bit ok;
        int p0;
        int popped;
        int base;

        vecs[0] = '{n: 1, ev: 32'h0000_0005, w: 4'd5,  wc: 8'd1, none: 1'b0};
        vecs[1] = '{n: 6, ev: 32'h0049_4949, w: 4'd4,  wc: 8'd3, none: 1'b0};
        vecs[2] = '{n: 0, ev: 32'h0000_0000, w: 4'd0,  wc: 8'd0, none: 1'b1};
        vecs[3] = '{n: 8, ev: 32'h0CCC_C377, w: 4'd12, wc: 8'd4, none: 1'b0};
        vecs[4] = '{n: 3, ev: 32'h0000_01FF, w: 4'd15, wc: 8'd2, none: 1'b0};

        // Reset asserted asynchronously in the middle of a READ
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;
        push(4'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (fifo_m.snn_ren) break;
        end
        check("snn_ren before reset", fifo_m.snn_ren, 1);
        reset = 1'b1;
        flush = 1'b1;
        #1;
        check("reset snn_ren",      fifo_m.snn_ren, 0);
        check("reset rd_count",     rd_count, 0);
        check("reset winner",       winner, 0);
        check("reset winner_count", winner_count, 0);
        check("reset no_spikes",    no_spikes, 0);
        check("reset result_valid", result_valid, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        flush = 1'b0;

        // One classification window per table entry
        for (int v = 0; v < 5; v++) begin
            p0      = rd_ptr;
            rd_addr = vecs[v].w;
            for (int i = 0; i < vecs[v].n; i++) push(vecs[v].ev[i]);
            repeat (28) @(negedge clock);
            check($sformatf("v%0d pops", v), rd_ptr - p0, vecs[v].n);
            for (int a = 0; a < 16; a++) begin
                rd_addr = 4'(a);
                @(negedge clock);
                check($sformatf("v%0d rd_count[%0d]", v, a), rd_count, exp_cnt(v, 4'(a)));
            end
            rd_addr = vecs[v].w;
            wait_result(ok);
            if (ok) begin
                check($sformatf("v%0d winner", v),       winner, vecs[v].w);
                check($sformatf("v%0d winner_count", v), winner_count, vecs[v].wc);
                check($sformatf("v%0d no_spikes", v),    no_spikes, vecs[v].none);
                check($sformatf("v%0d preclear rd", v),  rd_count, vecs[v].wc);
                check($sformatf("v%0d ren in eval", v),  ren_hist, 0);
                @(negedge clock);
                check($sformatf("v%0d postclear rd", v), rd_count, 0);
                check($sformatf("v%0d rv pulse", v),     result_valid, 0);
            end
        end

        // enable low: no reads issued
        enable  = 1'b0;
        rd_addr = 4'd11;
        p0      = rd_ptr;
        push(4'd11);
        repeat (10) @(negedge clock);
        check("disabled pops", rd_ptr - p0, 0);
        enable = 1'b1;
        wait_result(ok);
        if (ok) begin
            check("en winner",       winner, 11);
            check("en winner_count", winner_count, 1);
            check("en no_spikes",    no_spikes, 0);
        end

        // Back-pressure: FIFO stays non-empty across the window end
        @(negedge clock);
        base = rd_ptr;
        for (int i = 0; i < 30; i++) push(4'd6);
        wait_result(ok);
        popped = rd_ptr - base;
        if (ok) begin
            check("bp backlog left",   (wr_ptr != rd_ptr), 1);
            check("bp ren in eval",    ren_hist, 0);
            check("bp winner",         winner, 6);
            check("bp winner_count",   winner_count, popped);
        end
        rd_addr = 4'd6;
        for (int i = 0; i < 200; i++) begin
            if (rd_ptr == wr_ptr) break;
            @(negedge clock);
        end
        check("bp drained", (rd_ptr == wr_ptr), 1);
        repeat (4) @(negedge clock);
        check("bp next window count", rd_count, 30 - popped);

        // Saturation on the COUNT_W=2 instance
        wait_result_sat(ok);
        sat_target = 7;
        repeat (40) @(negedge clock);
        check("sat pops",     sat_pops, 7);
        check("sat rd_count", rd_count_s, 3);
        wait_result_sat(ok);
        if (ok) begin
            check("sat winner",       winner_s, 2);
            check("sat winner_count", winner_count_s, 3);
            check("sat no_spikes",    no_spikes_s, 0);
        end

        check("ren back-to-back", b2b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_event_reader.md
# spike_event_reader

Consumer at the far end of the SNN output spike FIFO. Pops neuron-address events from the FIFO with a two-cycle read handshake and keeps a saturating spike count per output neuron. At the end of each fixed classification window it scans the counts, reports the winning neuron, and clears the counts for the next window. A host-side port reads any neuron's count at any time.

## Interface
- WINDOW_CYCLES, default 1024: length of the classification window in enabled clock cycles; must be ≥ 2.
- COUNT_W, default 8: width of each per-neuron spike counter.
- N_NEURONS, fixed 16: number of output neurons; neuron addresses are 4 bits.

Ports (clock and reset first):
- clock  in  1  single system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- snn_event_n  in  1  FIFO empty flag; low means at least one spike event is pending.
- neuron_addr_out  in  4  FIFO read data; valid on the cycle after `snn_ren` is sampled high.
- snn_ren  out  1  FIFO read enable; a one-cycle pulse pops one entry.
- enable  in  1  when low, no new reads are issued and the window counter holds.
- rd_addr  in  4  host readout neuron select.
- rd_count  out  COUNT_W  registered count of neuron `rd_addr`, one cycle latency.
- winner  out  4  neuron index with the highest count in the last window; held until the next result.
- winner_count  out  COUNT_W  count of `winner`; held until the next result.
- no_spikes  out  1  high with a result when every count was 0; held until the next result.
- result_valid  out  1  one-cycle pulse when `winner`, `winner_count` and `no_spikes` update.

## Operation
- States: IDLE, READ, CAPTURE, EVAL, DONE.
- IDLE
  - If a window end is pending, go to EVAL.
  - Else if `enable` is high and `snn_event_n` is low, go to READ.
  - Else stay in IDLE.
  - The pending window end takes priority over a waiting event.
- READ: `snn_ren` = 1 for exactly this cycle; go to CAPTURE.
- CAPTURE: sample `neuron_addr_out`.
  - Increment that neuron's counter.
  - A counter at 2^COUNT_W−1 stays there (saturates).
  - Go to IDLE.
- Consequences of the handshake:
  - Throughput is at most one event per 3 cycles (IDLE→READ→CAPTURE).
  - `snn_ren` is never high on two consecutive cycles.
- Window counter
  - Counts cycles with `enable` high while in IDLE, READ or CAPTURE.
  - On reaching WINDOW_CYCLES−1 it wraps to 0 and sets `pending`.
  - It holds during EVAL and DONE.
- EVAL: 16 cycles; cycle k compares counter k against the running maximum.
  - Running maximum starts at counter 0 / index 0.
  - Replace only on strictly greater, so the lowest index wins ties.
  - No FIFO reads occur; events stay queued in the FIFO.
- DONE: one cycle.
  - Load `winner` and `winner_count`.
  - Set `no_spikes` = (max == 0).
  - Pulse `result_valid`.
  - Clear all 16 counters and `pending`.
  - Go to IDLE.
- Readout: `rd_count` ← counter[`rd_addr`] every cycle.
  - Reads during DONE return the pre-clear value.
  - Reads on the cycle after DONE return 0.
- Deasserting `enable` mid-handshake does not abort it: READ always completes through CAPTURE.

## Timing
- Reset values:
  - `snn_ren`, `result_valid`, `no_spikes` = 0.
  - `winner`, `winner_count`, `rd_count`, all counters, window counter = 0.
  - State = IDLE, `pending` = 0.
- Reset mid-handshake abandons the read. If the FIFO was popped, that event is lost.
- Event latency: `snn_event_n` low in IDLE → `snn_ren` high next cycle → counter updated at the end of CAPTURE (2 cycles later).
- Window end → `result_valid`: 1 to 3 cycles to drain to IDLE, then 16 EVAL cycles + 1 DONE cycle.
- A window end set while in READ or CAPTURE waits for CAPTURE to finish; the event is counted in the ending window.
- FIFO empty (`snn_event_n` high) after a pop: no further read is issued. The flag is re-sampled only in IDLE.

## Test plan
1. **Reset state.** Assert reset asynchronously mid-READ → `snn_ren` drops within the same cycle and all outputs read 0.
2. **Single event.** WINDOW_CYCLES=64. Push one event with address 5 → `snn_ren` pulses once; after the window, `result_valid` = 1, `winner` = 5, `winner_count` = 1, `no_spikes` = 0.
3. **Tie-break.** Push 3 events each to neurons 9 and 4 → `winner` = 4, `winner_count` = 3.
4. **Saturation.** COUNT_W=2, WINDOW_CYCLES=256. Push 7 events to neuron 2 → `rd_count`(rd_addr=2) = 3; `winner_count` = 3.
5. **Empty window.** No events → `no_spikes` = 1, `winner` = 0, `winner_count` = 0. On the next cycle after DONE, `rd_count` = 0 for every address.
6. **Back-pressure.** Keep the FIFO non-empty across a window end → no `snn_ren` during the 17 EVAL+DONE cycles. Reads resume in the next window, and those events are counted there.
